// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, NOP word,
// memory-size default and the PC legality helper.
package if_stage_pkg;

  localparam int          INSTR_MEM_SIZE = 128;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_BOOT  = 2'd0;
  localparam fetch_state_t ST_RUN   = 2'd1;
  localparam fetch_state_t ST_FAULT = 2'd2;

  // A PC is usable only if word-aligned and a full word fits inside memory.
  function automatic logic pc_is_illegal(input logic [31:0] pc, input logic [31:0] mem_bytes);
    return (pc[1:0] != 2'b00) || (pc > (mem_bytes - 32'd4));
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush wins over hold; a flush inserts a NOP and
// clears valid while leaving the PC fields as they were.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic        valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);

  logic [31:0] instr_r;
  logic [31:0] pc_r;
  logic [31:0] pc_plus4_r;
  logic        valid_r;

  // Pipeline register update: reset, flush, hold or load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r    <= NOP_INSTR;
      pc_r       <= 32'h0000_0000;
      pc_plus4_r <= 32'h0000_0000;
      valid_r    <= 1'b0;
    end else if (flush) begin
      instr_r <= NOP_INSTR;
      valid_r <= 1'b0;
    end else if (!hold) begin
      instr_r    <= instr;
      pc_r       <= pc;
      pc_plus4_r <= pc_plus4;
      valid_r    <= valid;
    end
  end

  assign id_instr    = instr_r;
  assign id_pc       = pc_r;
  assign id_pc_plus4 = pc_plus4_r;
  assign id_valid    = valid_r;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, legality check and
// BOOT/RUN/FAULT control feeding the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int          MEM_BYTES = INSTR_MEM_SIZE,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] Instr_addr,
  input  logic [31:0] Instruction,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] MEM_BYTES_W = 32'(MEM_BYTES);

  fetch_state_t state_r;
  fetch_state_t next_state_s;
  logic [31:0]  pc_r;
  logic [31:0]  next_pc_s;
  logic [31:0]  pc_plus4_s;
  logic [31:0]  count_r;
  logic         fault_r;
  logic         pc_illegal_s;
  logic         hold_s;
  logic         flush_s;
  logic         advance_s;
  logic         set_fault_s;

  assign pc_plus4_s   = pc_r + 32'd4;
  assign pc_illegal_s = pc_is_illegal(pc_r, MEM_BYTES_W);

  // Next-state / next-PC selection; in RUN a bad PC outranks redirect and stall.
  always_comb begin
    next_state_s = state_r;
    next_pc_s    = pc_r;
    hold_s       = 1'b1;
    flush_s      = 1'b0;
    advance_s    = 1'b0;
    set_fault_s  = 1'b0;
    case (state_r)
      ST_BOOT: begin
        next_state_s = pc_illegal_s ? ST_FAULT : ST_RUN;
        set_fault_s  = pc_illegal_s;
      end
      ST_RUN: begin
        if (pc_illegal_s) begin
          next_state_s = ST_FAULT;
          set_fault_s  = 1'b1;
          flush_s      = 1'b1;
        end else if (redirect_valid) begin
          next_pc_s = redirect_target;
          flush_s   = 1'b1;
        end else if (stall) begin
          hold_s = 1'b1;
        end else begin
          next_pc_s = pc_plus4_s;
          hold_s    = 1'b0;
          advance_s = 1'b1;
        end
      end
      ST_FAULT: begin
        flush_s = 1'b1;
      end
      default: begin
        next_state_s = ST_FAULT;
        set_fault_s  = 1'b1;
        flush_s      = 1'b1;
      end
    endcase
  end

  // PC, FSM state, sticky fault flag and delivered-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BOOT;
      pc_r    <= RESET_PC;
      fault_r <= 1'b0;
      count_r <= 32'h0000_0000;
    end else begin
      state_r <= next_state_s;
      pc_r    <= next_pc_s;
      fault_r <= fault_r | set_fault_s;
      count_r <= count_r + {31'd0, advance_s};
    end
  end

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold        (hold_s),
    .flush       (flush_s),
    .instr       (Instruction),
    .pc          (pc_r),
    .pc_plus4    (pc_plus4_s),
    .valid       (1'b1),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_valid    (id_valid)
  );

  assign Instr_addr  = pc_r;
  assign fetch_fault = fault_r;
  assign fetch_count = count_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected deliveries are queued by the stimulus
// and popped by a monitor whenever a new instruction reaches ID.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] Instr_addr;
  logic [31:0] Instruction;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [0:31];
  logic [31:0] exp_count;
  logic [31:0] last_count;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  always_comb Instruction = (Instr_addr < 32'd128) ? mem[Instr_addr[6:2]] : 32'hDEAD_BEEF;

  if_stage #(.MEM_BYTES(128), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .Instr_addr      (Instr_addr),
    .Instruction     (Instruction),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4),
    .id_valid        (id_valid),
    .fetch_fault     (fetch_fault),
    .fetch_count     (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    exp_t e;
    exp_count = exp_count + 32'd1;
    e.instr = mem[a[6:2]];
    e.pc    = a;
    e.cnt   = exp_count;
    sb_q.push_back(e);
  endtask

  task automatic chk_reset_values();
    chk("rst_addr",     Instr_addr,  32'h0);
    chk("rst_id_instr", id_instr,    32'h0);
    chk("rst_id_pc",    id_pc,       32'h0);
    chk("rst_id_pc4",   id_pc_plus4, 32'h0);
    chk("rst_id_valid", {31'd0, id_valid},    32'h0);
    chk("rst_fault",    {31'd0, fetch_fault}, 32'h0);
    chk("rst_count",    fetch_count, 32'h0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1 chk_reset_values();
    exp_count = 32'h0;
    #1 rst_n = 1'b1;
  endtask

  // Monitor: a new delivery is a valid IF/ID entry with an advanced counter.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && id_valid && (fetch_count != last_count)) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_delivery: got instr %h pc %h, expected none", id_instr, id_pc);
      end else begin
        e = sb_q.pop_front();
        chk("sb_id_instr", id_instr,    e.instr);
        chk("sb_id_pc",    id_pc,       e.pc);
        chk("sb_id_pc4",   id_pc_plus4, e.pc + 32'd4);
        chk("sb_count",    fetch_count, e.cnt);
      end
    end
    last_count = fetch_count;
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    mem[0] = 32'h0000_0011;
    mem[1] = 32'h0000_0022;
    mem[2] = 32'h0000_0033;
    exp_count       = 32'h0;
    last_count      = 32'h0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    rst_n           = 1'b1;
    #1 rst_n = 1'b0;
    #2 chk_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // BOOT edge: PC held, nothing delivered
    tick();
    chk("boot_addr",  Instr_addr, 32'h0);
    chk("boot_valid", {31'd0, id_valid}, 32'h0);

    // free-running fetch of 0x11, 0x22
    expect_fetch(32'h0); tick();
    chk("run_addr1", Instr_addr, 32'h4);
    expect_fetch(32'h4); tick();
    chk("run_addr2", Instr_addr, 32'h8);

    // two stall cycles at PC=8
    stall = 1'b1;
    tick(); tick();
    chk("stall_addr",  Instr_addr, 32'h8);
    chk("stall_instr", id_instr,   32'h22);
    chk("stall_pc",    id_pc,      32'h4);
    chk("stall_valid", {31'd0, id_valid}, 32'h1);
    chk("stall_count", fetch_count, 32'd2);
    stall = 1'b0;
    expect_fetch(32'h8); tick();
    chk("run_count3", fetch_count, 32'd3);
    chk("run_addr3",  Instr_addr,  32'hC);

    // redirect wins over a simultaneous stall
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
    tick();
    chk("redir_addr",  Instr_addr, 32'h40);
    chk("redir_valid", {31'd0, id_valid}, 32'h0);
    chk("redir_instr", id_instr,   32'h0);
    chk("redir_count", fetch_count, 32'd3);
    stall = 1'b0; redirect_valid = 1'b0;
    expect_fetch(32'h40); tick();
    expect_fetch(32'h44); tick();
    chk("redir_addr2", Instr_addr, 32'h48);

    // misaligned redirect target
    redirect_valid = 1'b1; redirect_target = 32'h7E;
    tick();
    chk("mis_addr",   Instr_addr, 32'h7E);
    chk("mis_fault0", {31'd0, fetch_fault}, 32'h0);
    redirect_valid = 1'b0;
    tick();
    chk("mis_fault1", {31'd0, fetch_fault}, 32'h1);
    chk("mis_valid",  {31'd0, id_valid},    32'h0);
    chk("mis_addr2",  Instr_addr, 32'h7E);
    // FAULT ignores redirect
    redirect_valid = 1'b1; redirect_target = 32'h10;
    tick();
    chk("flt_addr",  Instr_addr, 32'h7E);
    chk("flt_fault", {31'd0, fetch_fault}, 32'h1);
    chk("flt_count", fetch_count, 32'd5);
    redirect_valid = 1'b0;

    // reset from FAULT, then BOOT/RUN from RESET_PC
    async_reset();
    tick();
    chk("reboot_addr", Instr_addr, 32'h0);
    expect_fetch(32'h0); tick();
    chk("reboot_run", Instr_addr, 32'h4);

    // last legal word, then sequential step onto 0x80
    redirect_valid = 1'b1; redirect_target = 32'h7C;
    tick();
    chk("edge_addr", Instr_addr, 32'h7C);
    redirect_valid = 1'b0;
    expect_fetch(32'h7C); tick();
    chk("edge_addr2",  Instr_addr, 32'h80);
    chk("edge_fault0", {31'd0, fetch_fault}, 32'h0);
    tick();
    chk("edge_fault1", {31'd0, fetch_fault}, 32'h1);
    chk("edge_valid",  {31'd0, id_valid},    32'h0);

    // out-of-range redirect to 0x80
    async_reset();
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h80;
    tick();
    chk("oor_addr",   Instr_addr, 32'h80);
    chk("oor_fault0", {31'd0, fetch_fault}, 32'h0);
    redirect_valid = 1'b0;
    tick();
    chk("oor_fault1", {31'd0, fetch_fault}, 32'h1);
    chk("oor_valid",  {31'd0, id_valid},    32'h0);
    tick();
    chk("oor_frozen", Instr_addr, 32'h80);
    chk("oor_count",  fetch_count, 32'd0);

    tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
